// File: rtl/ball_motion.sv
// rtl/ball_motion.sv - per-frame ball physics and collision unit
// Collisions are latched pixel-accurately during the scan and applied once per frame at the update line.
module ball_motion #(
   parameter int BALL_SIZE    = 6,
   parameter int PADDLE_WIDTH = 31,
   parameter int SERVE_X      = 128,
   parameter int SERVE_Y      = 180,
   parameter int TOP_Y        = 16,
   parameter int MISS_Y       = 232,
   parameter int UPDATE_LINE  = 240,
   parameter int SERVE_FRAMES = 60
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [8:0] hpos,
   input  logic [8:0] vpos,
   input  logic       ball_gfx,
   input  logic       paddle_gfx,
   input  logic       brick_gfx,
   input  logic       brick_present,
   input  logic [6:0] brick_index,
   input  logic       lr_border,
   input  logic [8:0] paddle_pos,
   input  logic       lives_zero,
   output logic [8:0] ball_x,
   output logic [8:0] ball_y,
   output logic       ball_dir_x,
   output logic       ball_dir_y,
   output logic       ball_speed_x,
   output logic       brick_clr,
   output logic [6:0] brick_clr_index,
   output logic       incscore,
   output logic       declives,
   output logic       in_play
);

   localparam int            CW         = $clog2(SERVE_FRAMES);
   localparam logic [CW-1:0] LAST_SERVE = CW'(SERVE_FRAMES - 1);
   localparam logic [8:0]    SX         = 9'(SERVE_X);
   localparam logic [8:0]    SY         = 9'(SERVE_Y);
   localparam logic [8:0]    TY         = 9'(TOP_Y);
   localparam logic [8:0]    MY         = 9'(MISS_Y);
   localparam logic [8:0]    UL         = 9'(UPDATE_LINE);

   // The three paddle zones (rel 0-7, 8-23, 24+) need a paddle at least 24 pixels wide.
   if (BALL_SIZE < 1 || PADDLE_WIDTH < 24) begin : g_bad_geometry
      $error("ball_motion: unsupported BALL_SIZE/PADDLE_WIDTH");
   end

   typedef enum logic {SERVE, PLAY} state_t;

   state_t        state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic          upd;
   logic          hit_x, hit_paddle, hit_brick;
   logic [8:0]    rel;
   logic [6:0]    hit_idx;
   logic [8:0]    x_nx, y_nx;
   logic          dx_nx, dy_nx, sp_nx;
   logic          clr_nx, dec_nx;

   assign upd     = (vpos == UL) && (hpos == 9'd0);
   assign in_play = (state == PLAY);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= SERVE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      x_nx     = ball_x;
      y_nx     = ball_y;
      dx_nx    = ball_dir_x;
      dy_nx    = ball_dir_y;
      sp_nx    = ball_speed_x;
      clr_nx   = 1'b0;
      dec_nx   = 1'b0;
      if (upd) begin
         case (state)
            SERVE: begin
               // With no lives left the counter parks at its last value until play can resume.
               if (cnt == LAST_SERVE) begin
                  if (!lives_zero) begin
                     state_nx = PLAY;
                     cnt_nx   = '0;
                     dy_nx    = 1'b0;
                  end
               end else begin
                  cnt_nx = cnt + CW'(1);
               end
            end
            PLAY: begin
               if (hit_x) dx_nx = ~ball_dir_x;
               if (hit_paddle) begin
                  dy_nx = 1'b0;
                  dx_nx = (rel >= 9'd16);
                  sp_nx = (rel < 9'd8) || (rel >= 9'd24);
               end else if (hit_brick) begin
                  dy_nx = ~ball_dir_y;
               end
               if (ball_y <= TY) dy_nx = 1'b1;
               x_nx   = dx_nx ? ball_x + {7'd0, sp_nx, ~sp_nx} : ball_x - {7'd0, sp_nx, ~sp_nx};
               y_nx   = dy_nx ? ball_y + 9'd2 : ball_y - 9'd2;
               clr_nx = hit_brick;
               if (ball_y >= MY && !hit_paddle) begin
                  dec_nx   = 1'b1;
                  state_nx = SERVE;
                  x_nx     = SX;
                  y_nx     = SY;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt             <= '0;
         ball_x          <= SX;
         ball_y          <= SY;
         ball_dir_x      <= 1'b1;
         ball_dir_y      <= 1'b0;
         ball_speed_x    <= 1'b0;
         brick_clr       <= 1'b0;
         incscore        <= 1'b0;
         declives        <= 1'b0;
         brick_clr_index <= '0;
      end else begin
         cnt          <= cnt_nx;
         ball_x       <= x_nx;
         ball_y       <= y_nx;
         ball_dir_x   <= dx_nx;
         ball_dir_y   <= dy_nx;
         ball_speed_x <= sp_nx;
         brick_clr    <= clr_nx;
         incscore     <= clr_nx;
         declives     <= dec_nx;
         if (clr_nx) brick_clr_index <= hit_idx;
      end
   end

   // Only the first paddle pixel and the first brick pixel of a frame are captured.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hit_x      <= 1'b0;
         hit_paddle <= 1'b0;
         hit_brick  <= 1'b0;
         rel        <= '0;
         hit_idx    <= '0;
      end else if (upd) begin
         hit_x      <= 1'b0;
         hit_paddle <= 1'b0;
         hit_brick  <= 1'b0;
      end else if (state == PLAY) begin
         if (ball_gfx && lr_border) hit_x <= 1'b1;
         if (ball_gfx && paddle_gfx && !hit_paddle) begin
            hit_paddle <= 1'b1;
            rel        <= hpos - paddle_pos;
         end
         if (ball_gfx && brick_gfx && brick_present && !lr_border && !hit_brick) begin
            hit_brick <= 1'b1;
            hit_idx   <= brick_index;
         end
      end
   end

endmodule

// File: tb/tb_ball_motion.sv
// tb/tb_ball_motion.sv - directed scoreboard bench for ball_motion
module tb_ball_motion;

   logic       clk = 1'b0;
   logic       reset;
   logic [8:0] hpos, vpos, paddle_pos;
   logic       ball_gfx, paddle_gfx, brick_gfx, brick_present, lr_border, lives_zero;
   logic [6:0] brick_index;
   logic [8:0] ball_x, ball_y;
   logic       ball_dir_x, ball_dir_y, ball_speed_x;
   logic       brick_clr, incscore, declives, in_play;
   logic [6:0] brick_clr_index;

   ball_motion dut (
      .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos),
      .ball_gfx(ball_gfx), .paddle_gfx(paddle_gfx), .brick_gfx(brick_gfx),
      .brick_present(brick_present), .brick_index(brick_index), .lr_border(lr_border),
      .paddle_pos(paddle_pos), .lives_zero(lives_zero),
      .ball_x(ball_x), .ball_y(ball_y), .ball_dir_x(ball_dir_x), .ball_dir_y(ball_dir_y),
      .ball_speed_x(ball_speed_x), .brick_clr(brick_clr), .brick_clr_index(brick_clr_index),
      .incscore(incscore), .declives(declives), .in_play(in_play)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [8:0] x, y;
      logic       dx, dy, sp, play, clr, inc, dec;
      logic [6:0] idx;
   } exp_t;
   exp_t sb[$];

   int         m_x, m_y, m_cnt, m_rel;
   bit         m_dx, m_dy, m_sp, m_play, m_hx, m_hp, m_hb;
   logic [6:0] m_bidx, m_last;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_x = 128; m_y = 180; m_cnt = 0; m_rel = 0;
      m_dx = 1; m_dy = 0; m_sp = 0; m_play = 0;
      m_hx = 0; m_hp = 0; m_hb = 0; m_bidx = 0; m_last = 0;
      sb.delete();
   endtask

   task automatic idle();
      vpos = 9'd100; hpos = 9'd50;
      ball_gfx = 0; paddle_gfx = 0; brick_gfx = 0; brick_present = 0; lr_border = 0;
      brick_index = 7'd0;
   endtask

   // Frame update in the reference model; pushes the expected post-update outputs.
   task automatic model_upd();
      exp_t e;
      bit   nx, ny, ns;
      e.clr = 0; e.inc = 0; e.dec = 0;
      if (!m_play) begin
         if (m_cnt == 59) begin
            if (!lives_zero) begin m_play = 1; m_cnt = 0; m_dy = 0; end
         end else m_cnt++;
      end else begin
         nx = m_dx; ny = m_dy; ns = m_sp;
         if (m_hx) nx = !nx;
         if (m_hp) begin
            ny = 0;
            nx = (m_rel >= 16);
            ns = (m_rel < 8) || (m_rel >= 24);
         end else if (m_hb) ny = !ny;
         if (m_y <= 16) ny = 1;
         if (m_hb) begin e.clr = 1; e.inc = 1; m_last = m_bidx; end
         m_dx = nx; m_dy = ny; m_sp = ns;
         if (m_y >= 232 && !m_hp) begin
            e.dec = 1; m_play = 0; m_x = 128; m_y = 180;
         end else begin
            m_x = (m_x + (nx ? (ns ? 2 : 1) : (ns ? -2 : -1)) + 512) % 512;
            m_y = (m_y + (ny ? 2 : -2) + 512) % 512;
         end
      end
      m_hx = 0; m_hp = 0; m_hb = 0;
      e.x = 9'(m_x); e.y = 9'(m_y); e.dx = m_dx; e.dy = m_dy; e.sp = m_sp;
      e.play = m_play; e.idx = m_last;
      sb.push_back(e);
   endtask

   task automatic pix(input bit b, input bit p, input bit k, input bit pr, input bit lr,
                      input logic [6:0] idx, input int h);
      @(negedge clk);
      vpos = 9'd100; hpos = 9'(h);
      ball_gfx = b; paddle_gfx = p; brick_gfx = k; brick_present = pr; lr_border = lr;
      brick_index = idx;
      if (m_play) begin
         if (b && lr) m_hx = 1;
         if (b && p && !m_hp) begin m_hp = 1; m_rel = (h - int'(paddle_pos) + 512) % 512; end
         if (b && k && pr && !lr && !m_hb) begin m_hb = 1; m_bidx = idx; end
      end
      @(negedge clk);
      idle();
   endtask

   task automatic frame();
      exp_t e;
      @(negedge clk);
      idle();
      vpos = 9'd240; hpos = 9'd0;
      model_upd();
      @(negedge clk);
      hpos = 9'd1;
      e = sb.pop_front();
      check("ball_x", ball_x, e.x);
      check("ball_y", ball_y, e.y);
      check("dir_x", ball_dir_x, e.dx);
      check("dir_y", ball_dir_y, e.dy);
      check("speed_x", ball_speed_x, e.sp);
      check("in_play", in_play, e.play);
      check("brick_clr", brick_clr, e.clr);
      check("incscore", incscore, e.inc);
      check("declives", declives, e.dec);
      check("brick_clr_index", brick_clr_index, e.idx);
      @(negedge clk);
      check("pulse_clr_one_cycle", brick_clr, 0);
      check("pulse_inc_one_cycle", incscore, 0);
      check("pulse_dec_one_cycle", declives, 0);
      idle();
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_x"}, ball_x, 128);
      check({tag, "_y"}, ball_y, 180);
      check({tag, "_dx"}, ball_dir_x, 1);
      check({tag, "_dy"}, ball_dir_y, 0);
      check({tag, "_sp"}, ball_speed_x, 0);
      check({tag, "_play"}, in_play, 0);
      check({tag, "_clr"}, brick_clr, 0);
      check({tag, "_inc"}, incscore, 0);
      check({tag, "_dec"}, declives, 0);
   endtask

   initial begin
      int n;
      reset = 0; lives_zero = 0; paddle_pos = 9'd100;
      idle();
      model_reset();
      repeat (3) @(negedge clk);
      check_reset_values("reset");
      reset = 1;

      // Serve: 59 frames held, launch on the 60th, first move on the 61st.
      repeat (59) frame();
      check("serve_held", in_play, 0);
      frame();
      check("launch", in_play, 1);
      frame();
      check("first_move_y", ball_y, 178);
      check("first_move_x", ball_x, 129);

      // Side border flips dir_x.
      pix(1, 0, 0, 0, 1, 0, 60);
      frame();
      check("border_dir_x", ball_dir_x, 0);

      // Paddle zones; the second paddle pixel in the rel=4 frame must be ignored.
      pix(1, 1, 0, 0, 0, 0, 104);
      pix(1, 1, 0, 0, 0, 0, 120);
      frame();
      check("paddle_rel4_speed", ball_speed_x, 1);
      check("paddle_rel4_dir", ball_dir_x, 0);
      pix(1, 1, 0, 0, 0, 0, 112); frame();
      check("paddle_rel12_speed", ball_speed_x, 0);
      pix(1, 1, 0, 0, 0, 0, 116); frame();
      check("paddle_rel16_dir", ball_dir_x, 1);
      pix(1, 1, 0, 0, 0, 0, 124); frame();
      check("paddle_rel24_speed", ball_speed_x, 1);
      pix(1, 1, 0, 0, 0, 0, 107); frame();
      pix(1, 1, 0, 0, 0, 0, 99);  frame();

      // Fly up to the top wall.
      n = 0;
      while (m_y > 16 && n < 200) begin frame(); n++; end
      check("top_reached_in_bound", n < 200, 1);
      frame();
      check("top_wall_dir_y", ball_dir_y, 1);

      // Two bricks in one frame: only the first is cleared.
      pix(1, 0, 1, 1, 0, 7'h15, 200);
      pix(1, 0, 1, 1, 0, 7'h16, 201);
      frame();
      check("double_brick_index", brick_clr_index, 7'h15);
      // Brick pixel on the border is a wall hit only; an absent brick is no hit.
      pix(1, 0, 1, 1, 1, 7'h20, 2);
      frame();
      pix(1, 0, 1, 0, 0, 7'h21, 50);
      frame();
      check("index_held", brick_clr_index, 7'h15);

      // Fall to the miss line; a brick in the miss frame pulses together with declives.
      n = 0;
      while (m_y < 232 && n < 300) begin frame(); n++; end
      check("miss_reached_in_bound", n < 300, 1);
      pix(1, 0, 1, 1, 0, 7'h33, 150);
      frame();
      check("miss_serve_x", ball_x, 128);
      check("miss_serve_y", ball_y, 180);

      // No lives: stay in serve.
      lives_zero = 1;
      repeat (100) frame();
      check("lives_zero_hold", in_play, 0);
      lives_zero = 0;
      frame();
      check("resume_play", in_play, 1);

      // Asynchronous reset with a brick hit latched.
      pix(1, 0, 1, 1, 0, 7'h44, 80);
      @(negedge clk);
      #2 reset = 0;
      #1 check_reset_values("async_reset");
      model_reset();
      @(negedge clk);
      @(negedge clk);
      reset = 1;
      frame();
      check("post_reset_no_clr", brick_clr, 0);
      repeat (58) frame();
      check("post_reset_serve", in_play, 0);
      frame();
      check("post_reset_launch", in_play, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ball_motion.md
Name: ball_motion

Overview:
- Per-frame ball physics and collision unit for the brick-smash game.
- Sits directly upstream of the game top level: owns ball position and direction registers and issues brick-clear requests.
- Drives the scoreboard stats inputs (incscore, declives).
- Collisions are detected pixel-accurately from graphics signals during the visible scan, latched, and applied once per frame during vertical blank.

Parameters:
- BALL_SIZE, 6, square ball edge in pixels
- PADDLE_WIDTH, 31, paddle width in pixels
- SERVE_X, 128, ball X after serve
- SERVE_Y, 180, ball Y after serve
- TOP_Y, 16, top wall; ball_y at or below this forces dir_y down
- MISS_Y, 232, ball_y at or above this while in PLAY counts as a miss
- UPDATE_LINE, 240, vpos of the per-frame update (hpos == 0)
- SERVE_FRAMES, 60, frames spent in SERVE before launch

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-low reset
- hpos  in  9  beam X from hvsync generator
- vpos  in  9  beam Y
- ball_gfx  in  1  ball pixel at current beam position
- paddle_gfx  in  1  paddle pixel
- brick_gfx  in  1  brick or border pixel
- brick_present  in  1  a brick exists at the current cell
- brick_index  in  7  index of the brick being scanned
- lr_border  in  1  beam is on the left/right border
- paddle_pos  in  9  paddle left X
- lives_zero  in  1  no lives remain
- ball_x  out  9  ball left X
- ball_y  out  9  ball top Y
- ball_dir_x  out  1  0 = left, 1 = right
- ball_dir_y  out  1  0 = up, 1 = down
- ball_speed_x  out  1  0 = 1 px/frame, 1 = 2 px/frame
- brick_clr  out  1  one-cycle request to clear a brick
- brick_clr_index  out  7  brick to clear; valid with brick_clr
- incscore  out  1  one-cycle pulse
- declives  out  1  one-cycle pulse
- in_play  out  1  state == PLAY

Behaviour:
- Reset values:
  - ball_x = SERVE_X, ball_y = SERVE_Y
  - dir_x = 1, dir_y = 0, speed_x = 0
  - all pulses 0, state SERVE, serve counter 0, all hit flags 0

Update strobe:
- upd = (vpos == UPDATE_LINE && hpos == 0); exactly one cycle per frame.

Hit latches:
- Set during the frame; cleared on upd. Set only in PLAY.
- hit_x: set on ball_gfx && lr_border.
- hit_paddle: set on ball_gfx && paddle_gfx.
  - On the same cycle, capture rel = hpos - paddle_pos (9-bit, mod 512).
  - Only the first paddle pixel hit in the frame captures rel.
- hit_brick: set on ball_gfx && brick_gfx && brick_present && !lr_border.
  - The first such pixel in the frame captures brick_index; later brick hits in the same frame are ignored.

State machine:
- SERVE:
  - Ball held at SERVE_X/SERVE_Y; counter increments on each upd.
  - When counter reaches SERVE_FRAMES-1 at upd and !lives_zero: go to PLAY with dir_y = 0, counter cleared.
  - If lives_zero, stay in SERVE indefinitely.
- PLAY, at upd, evaluated in this order:
  1. hit_x → dir_x inverted.
  2. hit_paddle → dir_y = 0, dir_x = (rel >= 16), speed_x = (rel < 8 || rel >= 24). Paddle overrides brick Y-reflection.
  3. else hit_brick → dir_y inverted.
  4. ball_y <= TOP_Y → dir_y = 1.
  5. Move using the new directions: ball_x ± (1 + speed_x), ball_y ± 2. Arithmetic is 9-bit, wraps mod 512, no saturation.
  6. If the pre-move ball_y >= MISS_Y and !hit_paddle: declives = 1 for the upd+1 cycle, state SERVE, ball reset to SERVE_X/SERVE_Y. The move is discarded.
- brick_clr and incscore:
  - Both pulse on the upd+1 cycle when hit_brick was set at upd in PLAY.
  - brick_clr_index is held stable until the next pulse.
  - At most one brick is cleared per frame.
- Simultaneous events:
  - hit_x and hit_brick in one frame: both reflections apply.
  - Miss and brick in one frame: brick_clr, incscore and declives all pulse on the same cycle.
- Async reset mid-frame: all state returns to reset values immediately; the first upd after release counts as serve frame 0.

Test Plan:
1. Reset low then released; run 60 frames → ball stays at (128,180) through SERVE. in_play rises at the 60th upd; on the next upd ball_y = 178.
2. Ball at x = 10, dir_x = 0, speed_x = 0, overlapping lr_border one frame → at upd dir_x = 1 and ball_x = 11.
3. Paddle hit with rel = 4, ball_y = 220, dir_y = 1 → dir_y = 0, dir_x = 0, speed_x = 1, ball_x decreases by 2, ball_y = 218. Repeat with rel = 12 → speed_x = 0, dir_x = 0.
4. Two brick hits in one frame, indices 0x15 then 0x16 → a single brick_clr and incscore pulse at upd+1 with index 0x15; dir_y inverted once.
5. ball_y = 234, no paddle hit → declives pulses for one cycle, state SERVE, ball back at (128,180). With lives_zero = 1, in_play stays 0 after 100 frames.
6. Reset asserted while hit_brick is latched → no brick_clr or incscore pulse follows; outputs equal reset values.
